fcmp_pipe: RTL and testbench



---
 rtl/fcmp_pipe_if.sv | 29 ++
 rtl/fcmp_pipe.sv | 138 +++++++++++++
 tb/tb_fcmp_pipe.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fcmp_pipe_if.sv
// Operation/result channel of the FP compare/select unit.
// The master side issues operations and consumes results; the slave side is the unit itself.
interface fcmp_pipe_if #(
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [31:0]      in_x1;
   logic [31:0]      in_x2;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic [TAG_W-1:0] out_tag;
   logic             out_nan;

   // A transfer happens on a rising edge where valid and ready are both high.
   // A producer holds its payload steady while valid is high and ready is low.
   modport master (
      output in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag, out_nan
   );

   modport slave (
      input  in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag, out_nan
   );
endinterface

// File: rtl/fcmp_pipe.sv
// Two-stage IEEE-754 single-precision compare/select (flt, fle, feq, fmin, fmax).
// Stage 1 captures operands plus NaN/zero classification; stage 2 is the output register.
module fcmp_pipe #(
   parameter int TAG_W = 5
) (
   input  logic       clk,
   input  logic       rst,
   fcmp_pipe_if.slave bus
);
   localparam logic [2:0] OP_FLT  = 3'd0;
   localparam logic [2:0] OP_FLE  = 3'd1;
   localparam logic [2:0] OP_FEQ  = 3'd2;
   localparam logic [2:0] OP_FMIN = 3'd3;
   localparam logic [2:0] OP_FMAX = 3'd4;
   localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

   logic             r_s1_valid;
   logic [2:0]       r_s1_op;
   logic [31:0]      r_s1_a;
   logic [31:0]      r_s1_b;
   logic [TAG_W-1:0] r_s1_tag;
   logic             r_s1_nan_a;
   logic             r_s1_nan_b;
   logic             r_s1_zero_a;
   logic             r_s1_zero_b;

   logic             r_s2_valid;
   logic [31:0]      r_s2_result;
   logic [TAG_W-1:0] r_s2_tag;
   logic             r_s2_nan;

   logic             w_s2_load;
   logic             w_s1_load;
   logic             w_in_fire;
   logic             w_any_nan;
   logic             w_both_zero;
   logic             w_lt;
   logic             w_eq;
   logic [31:0]      w_result;

   function automatic logic f_is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   function automatic logic f_is_zero(input logic [31:0] x);
      return x[30:0] == 31'd0;
   endfunction

   assign w_s2_load    = !r_s2_valid || bus.out_ready;
   assign w_s1_load    = !r_s1_valid || w_s2_load;
   assign bus.in_ready = !rst && w_s1_load;
   assign w_in_fire    = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1_op     <= 3'd0;
         r_s1_a      <= 32'd0;
         r_s1_b      <= 32'd0;
         r_s1_tag    <= '0;
         r_s1_nan_a  <= 1'b0;
         r_s1_nan_b  <= 1'b0;
         r_s1_zero_a <= 1'b0;
         r_s1_zero_b <= 1'b0;
      end else if (w_s1_load) begin
         r_s1_valid <= w_in_fire;
         if (w_in_fire) begin
            r_s1_op     <= bus.in_op;
            r_s1_a      <= bus.in_x1;
            r_s1_b      <= bus.in_x2;
            r_s1_tag    <= bus.in_tag;
            r_s1_nan_a  <= f_is_nan(bus.in_x1);
            r_s1_nan_b  <= f_is_nan(bus.in_x2);
            r_s1_zero_a <= f_is_zero(bus.in_x1);
            r_s1_zero_b <= f_is_zero(bus.in_x2);
         end
      end
   end

   // Sign-magnitude ordering: for two negatives the larger magnitude is the smaller value.
   always_comb begin
      w_any_nan   = r_s1_nan_a || r_s1_nan_b;
      w_both_zero = r_s1_zero_a && r_s1_zero_b;
      w_lt        = 1'b0;
      if (!w_any_nan && !w_both_zero) begin
         if (r_s1_a[31] != r_s1_b[31])
            w_lt = r_s1_a[31];
         else if (!r_s1_a[31])
            w_lt = r_s1_a[30:0] < r_s1_b[30:0];
         else
            w_lt = r_s1_b[30:0] < r_s1_a[30:0];
      end
      w_eq = !w_any_nan && ((r_s1_a == r_s1_b) || w_both_zero);

      w_result = 32'd0;
      case (r_s1_op)
         OP_FLT: w_result = {31'd0, w_lt};
         OP_FLE: w_result = {31'd0, w_lt || w_eq};
         OP_FEQ: w_result = {31'd0, w_eq};
         OP_FMIN: begin
            if (r_s1_nan_a && r_s1_nan_b)                  w_result = CANON_NAN;
            else if (r_s1_nan_a)                           w_result = r_s1_b;
            else if (r_s1_nan_b)                           w_result = r_s1_a;
            else if (w_both_zero && (r_s1_a[31] != r_s1_b[31])) w_result = 32'h8000_0000;
            else                                           w_result = w_lt ? r_s1_a : r_s1_b;
         end
         OP_FMAX: begin
            if (r_s1_nan_a && r_s1_nan_b)                  w_result = CANON_NAN;
            else if (r_s1_nan_a)                           w_result = r_s1_b;
            else if (r_s1_nan_b)                           w_result = r_s1_a;
            else if (w_both_zero && (r_s1_a[31] != r_s1_b[31])) w_result = 32'h0000_0000;
            else                                           w_result = w_lt ? r_s1_b : r_s1_a;
         end
         default: w_result = 32'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid  <= 1'b0;
         r_s2_result <= 32'd0;
         r_s2_tag    <= '0;
         r_s2_nan    <= 1'b0;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_result <= w_result;
            r_s2_tag    <= r_s1_tag;
            r_s2_nan    <= w_any_nan;
         end
      end
   end

   assign bus.out_valid  = r_s2_valid;
   assign bus.out_result = r_s2_result;
   assign bus.out_tag    = r_s2_tag;
   assign bus.out_nan    = r_s2_nan;
endmodule

// File: tb/tb_fcmp_pipe.sv
// Bench for fcmp_pipe: vector table, hand-written latency/stall/reset sequences,
// and randomized traffic checked against an ordering-key reference model.
module tb_fcmp_pipe;
   localparam int TAG_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fcmp_pipe_if #(.TAG_W(TAG_W)) bus ();
   fcmp_pipe #(.TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [2:0]  op;
      logic [31:0] x1;
      logic [31:0] x2;
      logic [31:0] res;
      logic        nan;
   } vec_t;

   vec_t        vecs[$];
   logic [37:0] exp_q[$];
   logic [37:0] drv_exp;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          stalls   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: map each float onto a signed integer whose order is the float order
   // (both zeros map to 0), then apply the NaN and signed-zero select exceptions.
   function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic na, nb, lt, eq;
      longint ka, kb;
      logic [31:0] r;
      na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      ka = longint'({1'b0, a[30:0]});
      kb = longint'({1'b0, b[30:0]});
      if (a[31]) ka = -ka;
      if (b[31]) kb = -kb;
      lt = !(na || nb) && (ka < kb);
      eq = !(na || nb) && (ka == kb);
      case (op)
         3'd0: r = {31'd0, lt};
         3'd1: r = {31'd0, lt | eq};
         3'd2: r = {31'd0, eq};
         3'd3, 3'd4: begin
            if (na && nb)                r = 32'h7FC00000;
            else if (na)                 r = b;
            else if (nb)                 r = a;
            else if (ka == kb && a != b) r = (op == 3'd3) ? 32'h80000000 : 32'h00000000;
            else if (op == 3'd3)         r = lt ? a : b;
            else                         r = lt ? b : a;
         end
         default: r = 32'd0;
      endcase
      return {na | nb, r};
   endfunction

   function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input logic nan);
      vec_t v;
      v.op = op; v.x1 = a; v.x2 = b; v.res = res; v.nan = nan;
      return v;
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [31:0] v;
      case ($urandom_range(0, 9))
         0: v = 32'h00000000;
         1: v = 32'h80000000;
         2: v = 32'h7F800000;
         3: v = 32'hFF800000;
         4: v = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
         5: v = {1'($urandom_range(0, 1)), 8'h7F, 23'($urandom_range(0, 3))};
         default: v = $urandom;
      endcase
      return v;
   endfunction

   task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input logic [31:0] res, input logic nan);
      bus.in_op    = op;
      bus.in_x1    = a;
      bus.in_x2    = b;
      bus.in_tag   = tag;
      bus.in_valid = 1'b1;
      drv_exp      = {res, tag, nan};
   endtask

   task automatic drive_m(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag);
      logic [32:0] m;
      m = model(op, a, b);
      drive(op, a, b, tag, m[31:0], m[32]);
   endtask

   // Called just after a rising edge; returns just after the edge that took the op.
   task automatic wait_accept();
      int waited;
      waited = 0;
      @(negedge clk);
      while (!bus.in_ready && waited < 100) begin
         waited++;
         stalls++;
         @(negedge clk);
      end
      if (!bus.in_ready) chk("accept_timeout", waited, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
         waited++;
         @(posedge clk);
         #1;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   // Scoreboard: handshakes are judged at the falling edge, ahead of the edge that completes them.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_out: got result %0h tag %0h with nothing outstanding",
                        bus.out_result, bus.out_tag);
            end else begin
               logic [37:0] e;
               e = exp_q.pop_front();
               chk("out_result", bus.out_result, e[37:6]);
               chk("out_tag", bus.out_tag, e[5:1]);
               chk("out_nan", bus.out_nan, e[0]);
            end
         end
         if (bus.in_valid && bus.in_ready) exp_q.push_back(drv_exp);
      end
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      int acc, sent, seen;
      bit have, pend;
      logic [37:0] held;
      logic [31:0] a, b;

      vecs.push_back(mk(3'd0, 32'hBF800000, 32'h3F800000, 32'h1, 1'b0));
      vecs.push_back(mk(3'd0, 32'hC0000000, 32'hBF800000, 32'h1, 1'b0));
      vecs.push_back(mk(3'd1, 32'h40000000, 32'h40000000, 32'h1, 1'b0));
      vecs.push_back(mk(3'd2, 32'h00000000, 32'h80000000, 32'h1, 1'b0));
      vecs.push_back(mk(3'd4, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0));
      vecs.push_back(mk(3'd0, 32'h7FC00000, 32'h3F800000, 32'h0, 1'b1));
      vecs.push_back(mk(3'd3, 32'h7FC00000, 32'hBF800000, 32'hBF800000, 1'b1));
      vecs.push_back(mk(3'd4, 32'hFFC00000, 32'h7F800001, 32'h7FC00000, 1'b1));
      vecs.push_back(mk(3'd3, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0));
      vecs.push_back(mk(3'd4, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0));
      vecs.push_back(mk(3'd0, 32'h00000000, 32'h80000000, 32'h0, 1'b0));
      vecs.push_back(mk(3'd3, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0));
      vecs.push_back(mk(3'd4, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0));
      vecs.push_back(mk(3'd0, 32'hFF800000, 32'hC1200000, 32'h1, 1'b0));
      vecs.push_back(mk(3'd0, 32'h7F800000, 32'h7F7FFFFF, 32'h0, 1'b0));
      vecs.push_back(mk(3'd1, 32'h7F7FFFFF, 32'h7F800000, 32'h1, 1'b0));
      vecs.push_back(mk(3'd2, 32'h7F800000, 32'h7F800000, 32'h1, 1'b0));
      vecs.push_back(mk(3'd1, 32'hBF800000, 32'hBF800001, 32'h0, 1'b0));
      vecs.push_back(mk(3'd5, 32'h3F800000, 32'h7FC00000, 32'h0, 1'b1));
      vecs.push_back(mk(3'd7, 32'h00000001, 32'h00000002, 32'h0, 1'b0));
      vecs.push_back(mk(3'd2, 32'h7FC00000, 32'h7FC00000, 32'h0, 1'b1));
      vecs.push_back(mk(3'd4, 32'h3F800000, 32'hBF800000, 32'h3F800000, 1'b0));
      vecs.push_back(mk(3'd3, 32'h3F800000, 32'hBF800000, 32'hBF800000, 1'b0));
      vecs.push_back(mk(3'd3, 32'h00000001, 32'h00000000, 32'h00000000, 1'b0));

      bus.in_valid  = 1'b0;
      bus.in_op     = 3'd0;
      bus.in_x1     = 32'd0;
      bus.in_x2     = 32'd0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;
      drv_exp       = '0;

      // Reset state
      #1 rst = 1'b1;
      #1;
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_result", bus.out_result, 0);
      chk("rst_out_tag", bus.out_tag, 0);
      chk("rst_out_nan", bus.out_nan, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", bus.in_ready, 1);
      @(posedge clk);
      #1;

      // Single op: valid one edge after the capture edge, i.e. two edges after presentation
      drive(3'd0, 32'hBF800000, 32'h3F800000, 5'd3, 32'h1, 1'b0);
      wait_accept();
      bus.in_valid = 1'b0;
      chk("lat_after_capture", bus.out_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_after_second_edge", bus.out_valid, 1);
      drain();

      // Back-to-back vector table
      stalls = 0;
      foreach (vecs[i]) begin
         drive(vecs[i].op, vecs[i].x1, vecs[i].x2, 5'(i), vecs[i].res, vecs[i].nan);
         wait_accept();
      end
      bus.in_valid = 1'b0;
      chk("stream_no_stall", stalls, 0);
      drain();

      // Backpressure: two ops buffer, then in_ready drops and the output holds
      bus.out_ready = 1'b0;
      acc  = 0;
      have = 0;
      held = '0;
      for (int c = 0; c < 5; c++) begin
         drive_m(3'(acc % 5), 32'h3F800000 + 32'(acc), 32'h40000000 - 32'(acc), 5'(10 + acc));
         @(negedge clk);
         if (bus.in_ready) acc++;
         if (bus.out_valid) begin
            if (!have) begin
               held = {bus.out_result, bus.out_tag, bus.out_nan};
               have = 1;
            end else begin
               chk("stall_hold", {bus.out_result, bus.out_tag, bus.out_nan}, held);
            end
         end
         @(posedge clk);
         #1;
      end
      chk("bp_accepted", acc, 2);
      chk("bp_in_ready_low", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drain();

      // Randomized traffic with random backpressure
      sent = 0;
      pend = 0;
      for (int c = 0; c < 2000 && sent < 250; c++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if (!pend && $urandom_range(0, 4) != 0) begin
            a = rand_fp();
            b = ($urandom_range(0, 5) == 0) ? a : rand_fp();
            drive_m(3'($urandom_range(0, 7)), a, b, 5'($urandom));
            pend = 1;
         end
         bus.in_valid = pend;
         @(negedge clk);
         if (pend && bus.in_ready) begin
            pend = 0;
            sent++;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("rand_sent", sent, 250);
      drain();

      // Asynchronous reset with both stages full
      bus.out_ready = 1'b0;
      drive_m(3'd3, 32'h40400000, 32'h40800000, 5'd21);
      wait_accept();
      drive_m(3'd4, 32'hC0400000, 32'hC0800000, 5'd22);
      wait_accept();
      bus.in_valid = 1'b0;
      chk("pre_rst_out_valid", bus.out_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_in_ready", bus.in_ready, 0);
      chk("mid_rst_out_tag", bus.out_tag, 0);
      chk("mid_rst_out_result", bus.out_result, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      bus.out_ready = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      chk("no_stale_after_rst", seen, 0);
      chk("ready_after_mid_rst", bus.in_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
